// File: rtl/multiplica_seq.sv
// multiplica_seq: radix-2 shift-add sequential multiplier.
// Works on operand magnitudes, LSB-first, one multiplier bit per clock.
// A single FIX cycle restores the sign, then derives the overflow flag and
// the truncated or saturated WIDTH-bit result.
// Latency: start sampled at edge k gives done=1 after edge k+WIDTH+1.
module multiplica_seq #(
  parameter int WIDTH    = 16,
  parameter bit SIGNED   = 1'b1,
  parameter bit SATURATE = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     C,
  output logic                 overflow
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);
  localparam logic [PW-1:0]    ONE_P    = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] SMAX     = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] UMAX     = {WIDTH{1'b1}};

  logic [1:0]       state;
  logic [PW-1:0]    mcand;   // shifted multiplicand magnitude
  logic [WIDTH-1:0] mplier;  // multiplier magnitude, consumed LSB first
  logic [PW-1:0]    acc;
  logic             sign;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic             sign_in;
  logic [PW-1:0]    prod_n;
  logic             ovf_n;
  logic [WIDTH-1:0] c_n;
  logic [WIDTH:0]   top_bits;
  logic             accept;

  // A start is honoured only while idle or holding a finished result.
  assign accept = start && ((state == S_IDLE) || (state == S_DONE));

  // Operand magnitudes and result sign. Negating -2^(WIDTH-1) in WIDTH bits
  // gives the same bit pattern, which read as unsigned is the correct
  // magnitude 2^(WIDTH-1). A zero operand forces a positive sign.
  always_comb begin
    mag_a   = A;
    mag_b   = B;
    sign_in = 1'b0;
    if (SIGNED) begin
      if (A[WIDTH-1]) mag_a = ~A + 1'b1;
      if (B[WIDTH-1]) mag_b = ~B + 1'b1;
      sign_in = (A[WIDTH-1] ^ B[WIDTH-1]) && (A != '0) && (B != '0);
    end
  end

  // Sign restoration, overflow detection and result selection for FIX.
  always_comb begin
    prod_n   = sign ? (~acc + ONE_P) : acc;
    top_bits = prod_n[PW-1:WIDTH-1];
    if (SIGNED) ovf_n = !((&top_bits) || !(|top_bits));
    else        ovf_n = |prod_n[PW-1:WIDTH];
    c_n = prod_n[WIDTH-1:0];
    if (SATURATE && ovf_n) begin
      if (SIGNED) c_n = sign ? SMIN : SMAX;
      else        c_n = UMAX;
    end
  end

  // Control FSM and shift-add datapath.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      sign     <= 1'b0;
      cnt      <= '0;
      product  <= '0;
      C        <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            sign   <= sign_in;
            acc    <= '0;
            cnt    <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_BIT) state <= S_FIX;
        end
        S_FIX: begin
          product  <= prod_n;
          C        <= c_n;
          overflow <= ovf_n;
          state    <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN) || (state == S_FIX);
  assign done = (state == S_DONE);

endmodule

// File: doc/multiplica_seq.md
Name: multiplica_seq

Overview:
Parametrised sequential multiplier: WIDTH-bit operands, radix-2 shift-add on operand magnitudes, sign fix-up at the end.
- Returns the full 2*WIDTH-bit product and a WIDTH-bit result.
- The WIDTH-bit result is either truncated or saturated, with an overflow flag.
- Multi-cycle replacement for the combinational 16-bit signed multiplier in the ALU datapath, driven by a start/done handshake from the control unit.

Parameters:
WIDTH, 16, operand and result width in bits (>= 4)
SIGNED, 1, 1 = two's-complement operands and result; 0 = unsigned
SATURATE, 0, 1 = result clamps on overflow; 0 = result is the low WIDTH bits of the product

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request a multiply; sampled only in IDLE or DONE
A  input  WIDTH  multiplicand
B  input  WIDTH  multiplier
busy  output  1  operation in progress
done  output  1  product/result/overflow valid; held until next accepted start
product  output  2*WIDTH  full-precision product (signed if SIGNED=1)
C  output  WIDTH  truncated or saturated result
overflow  output  1  product does not fit in WIDTH bits (signed range if SIGNED=1, unsigned otherwise)

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (including mid-operation) forces:
  - state IDLE
  - busy=0, done=0, overflow=0
  - product=0, C=0
  - internal registers cleared; any in-flight operation is discarded.
- States: IDLE, RUN, FIX, DONE.
- IDLE/DONE with start=1 at edge k:
  - Latch |A| and |B| as WIDTH-bit unsigned magnitudes. When SIGNED=0, or the operand's MSB=0, the magnitude is the raw value. The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and must not be lost.
  - Latch sign = A[MSB] xor B[MSB] (forced 0 when SIGNED=0).
  - Clear the 2*WIDTH-bit accumulator.
  - Go to RUN with bit counter = 0; busy=1, done=0.
- RUN, one multiplier bit per cycle, LSB first:
  - If the current multiplier bit is 1, add the shifted multiplicand into the accumulator. Additions are 2*WIDTH bits wide with no carry loss.
  - After WIDTH cycles, go to FIX.
- FIX, one cycle:
  - product = sign ? (~acc + 1) : acc.
  - Compute overflow and C.
  - Go to DONE; busy=0, done=1.
- Total latency: start sampled at edge k -> done=1 after edge k+WIDTH+1.
- overflow, SIGNED=1: set when product[2*WIDTH-1:WIDTH-1] is not all-equal.
- overflow, SIGNED=0: set when product[2*WIDTH-1:WIDTH] != 0.
- C, SATURATE=0: C = product[WIDTH-1:0].
- C, SATURATE=1 with overflow:
  - SIGNED=1: C = 0111..1 when sign=0, C = 1000..0 when sign=1.
  - SIGNED=0: C = 1111..1.
- Zero operands: product=0, overflow=0, sign forced 0 so no negative zero. Latency is unchanged (no early termination).
- start while in RUN or FIX is ignored; A and B may change freely after the accepting edge.
- DONE:
  - Outputs held stable until the next accepted start.
  - A start in DONE is accepted exactly as in IDLE; done drops on that edge.
  - DONE never returns to IDLE except via reset.
- busy and done are never both 1.

Test Plan:
1. WIDTH=16, SIGNED=1, SATURATE=0, A=3, B=-5 (0xFFFB), one-cycle start -> busy high 17 cycles, done after edge k+17, product=0xFFFFFFF1, C=0xFFF1, overflow=0.
2. A=0x8000, B=0x8000 -> product=0x40000000, overflow=1, C=0x0000; repeat with SATURATE=1 -> C=0x7FFF.
3. A=300, B=200 -> product=0x0000EA60, overflow=1, C=0xEA60 (SATURATE=0) / 0x7FFF (SATURATE=1); A=-300, B=200 with SATURATE=1 -> product=0xFFFF15A0, C=0x8000.
4. SIGNED=0: A=0xFFFF, B=0x0002 -> product=0x0001FFFE, overflow=1, C=0xFFFE; A=0x00FF, B=0x0100 -> product=0x0000FF00, overflow=0.
5. start pulsed again at cycle k+5 with different A and B -> ignored, result of the first operation unchanged. Back-to-back start in DONE -> done=0 next edge, new result after 17 more cycles.
6. reset asserted at cycle k+8 of a run -> next edge busy=0, done=0, product=0, C=0, overflow=0; a fresh start then completes normally.
